// File: rtl/pamux_if.sv
// rtl/pamux_if.sv - pamux client bus between a RAM window and the PSRAM arbiter
interface pamux_if;
  logic [21:0] address;
  logic        write;
  logic        read;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        busy;

  modport master (
    output address,
    output write,
    output read,
    output write_data,
    input  read_data,
    input  busy
  );

  modport slave (
    input  address,
    input  write,
    input  read,
    input  write_data,
    output read_data,
    output busy
  );
endinterface

// File: rtl/ram_window_unit.sv
// rtl/ram_window_unit.sv - CPU RAM window onto PSRAM with posted writes; RAMWIN_RDCACHE_EN adds a one-entry read cache
module ram_window_unit #(
  parameter int          ADDR_W     = 14,
  parameter logic [21:0] BASE_ADDR  = 22'h000000,
  parameter int          WBUF_DEPTH = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_EN,
  input  logic [ADDR_W-1:0]             i_MEM_ADDR,
  input  logic                          i_MEM_WR8,
  input  logic                          i_MEM_RD8,
  input  logic [7:0]                    i_MEM_DATA8,
  output logic [7:0]                    o_MEM_DATA8,
  output logic                          o_MEM_BUSY,
  output logic [$clog2(WBUF_DEPTH):0]   o_WBUF_LEVEL,
  output logic                          o_IDLE,
  pamux_if.master                       bus_Pamux
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(WBUF_DEPTH);

  if (ADDR_W < 8 || ADDR_W > 21) begin : g_bad_addr_w
    $error("ram_window_unit: ADDR_W must be in 8..21");
  end
  if ((BASE_ADDR & ((22'h1 << ADDR_W) - 22'h1)) != 22'h0) begin : g_bad_base
    $error("ram_window_unit: BASE_ADDR low ADDR_W bits must be zero");
  end
  if (WBUF_DEPTH < 2 || WBUF_DEPTH > 16 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ram_window_unit: WBUF_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {
    E_IDLE      = 2'd0,
    E_STROBE    = 2'd1,
    E_GAP       = 2'd2,
    E_WAIT_DONE = 2'd3
  } eng_state_t;

  eng_state_t state_q, state_d;

  // Posted-write FIFO storage and pointers
  logic [ADDR_W-1:0] fa_q [WBUF_DEPTH];
  logic [7:0]        fd_q [WBUF_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       count_q;

  // CPU-side tracking
  logic              served_q, busy_q, wr_pend_q, rd_pend_q, rd_wait_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [7:0]        req_data_q;
  logic [7:0]        rdata_q;

  // Bus engine registers
  logic              gate_q, eng_rd_q;
  logic [ADDR_W-1:0] eng_addr_q;
  logic [7:0]        eng_data_q;

  logic fifo_full, fifo_empty, accept, acc_wr, acc_rd, miss_rd, rd_hit;
  logic pop, can_push, push_new, push_pend, push, load_rd, done, rd_done;
  logic [ADDR_W-1:0] push_addr;
  logic [7:0]        push_data;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);

  // One access per i_EN assertion; a simultaneous write and read resolves to the write
  assign accept = i_EN && !served_q && (i_MEM_WR8 || i_MEM_RD8);
  assign acc_wr = accept && i_MEM_WR8;
  assign acc_rd = accept && !i_MEM_WR8;

  // Writes always drain first; a read only starts once the FIFO is empty
  assign pop     = (state_q == E_IDLE) && !fifo_empty;
  assign load_rd = (state_q == E_IDLE) && fifo_empty && rd_pend_q && i_EN;
  assign done    = (state_q == E_WAIT_DONE) && !bus_Pamux.busy;
  assign rd_done = done && eng_rd_q && rd_wait_q && !rd_pend_q && i_EN;

  // A full FIFO still takes a push in the same cycle a pop frees a slot
  assign can_push  = !fifo_full || pop;
  assign push_new  = acc_wr && can_push;
  assign push_pend = wr_pend_q && i_EN && can_push;
  assign push      = push_new || push_pend;
  assign push_addr = push_pend ? req_addr_q : i_MEM_ADDR;
  assign push_data = push_pend ? req_data_q : i_MEM_DATA8;

`ifdef RAMWIN_RDCACHE_EN
  logic              cv_q, hit_q, fifo_match;
  logic [ADDR_W-1:0] ca_q;
  logic [7:0]        cd_q;
  logic [PW-1:0]     slot_offs;

  // Look for any queued write to the requested address among occupied slots
  always_comb begin
    fifo_match = 1'b0;
    slot_offs  = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      slot_offs = PW'(i) - rp_q;
      if (({1'b0, slot_offs} < count_q) && (fa_q[i] == i_MEM_ADDR)) fifo_match = 1'b1;
    end
  end

  assign rd_hit  = acc_rd && cv_q && (ca_q == i_MEM_ADDR) && !fifo_match;
  assign miss_rd = acc_rd && !rd_hit;

  // Cache: refreshed by writes at push time, filled by completed bus reads
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cv_q <= 1'b0;
      ca_q <= '0;
      cd_q <= 8'h00;
    end else begin
      if (push && cv_q && (push_addr == ca_q)) cd_q <= push_data;
      if (rd_done) begin
        cv_q <= 1'b1;
        ca_q <= eng_addr_q;
        cd_q <= bus_Pamux.read_data;
      end
    end
  end
`else
  assign rd_hit  = 1'b0;
  assign miss_rd = acc_rd;
`endif

  // FIFO pointers and occupancy; pointers wrap naturally modulo the depth
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO entry storage, written on push
  always_ff @(posedge i_CLK) begin
    if (push) begin
      fa_q[wp_q] <= push_addr;
      fd_q[wp_q] <= push_data;
    end
  end

  // CPU side: served flag, stalled write, pending read, busy and read-data register
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      served_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_wait_q  <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= 8'h00;
      rdata_q    <= 8'hCC;
`ifdef RAMWIN_RDCACHE_EN
      hit_q      <= 1'b0;
`endif
    end else if (!i_EN) begin
      served_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_wait_q <= 1'b0;
`ifdef RAMWIN_RDCACHE_EN
      hit_q     <= 1'b0;
`endif
    end else begin
      if (accept) served_q <= 1'b1;
      if (acc_wr && !can_push) begin
        wr_pend_q  <= 1'b1;
        busy_q     <= 1'b1;
        req_addr_q <= i_MEM_ADDR;
        req_data_q <= i_MEM_DATA8;
      end
      if (push_pend) begin
        wr_pend_q <= 1'b0;
        busy_q    <= 1'b0;
      end
      if (miss_rd) begin
        rd_pend_q  <= 1'b1;
        rd_wait_q  <= 1'b1;
        busy_q     <= 1'b1;
        req_addr_q <= i_MEM_ADDR;
      end
      if (load_rd) rd_pend_q <= 1'b0;
      if (rd_done) begin
        rdata_q   <= bus_Pamux.read_data;
        busy_q    <= 1'b0;
        rd_wait_q <= 1'b0;
      end
`ifdef RAMWIN_RDCACHE_EN
      if (rd_hit) begin
        busy_q  <= 1'b1;
        hit_q   <= 1'b1;
        rdata_q <= cd_q;
      end
      if (hit_q) begin
        busy_q <= 1'b0;
        hit_q  <= 1'b0;
      end
`endif
    end
  end

  // Bus engine state register
  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= E_IDLE;
    else       state_q <= state_d;
  end

  // Bus engine next state: strobe, one unsampled gap cycle, then wait for busy low
  always_comb begin
    state_d = state_q;
    case (state_q)
      E_IDLE:      if (pop || load_rd) state_d = E_STROBE;
      E_STROBE:    state_d = E_GAP;
      E_GAP:       state_d = E_WAIT_DONE;
      E_WAIT_DONE: if (!bus_Pamux.busy) state_d = E_IDLE;
      default:     state_d = E_IDLE;
    endcase
  end

  // Bus engine transaction registers; gate spans E_STROBE through E_WAIT_DONE
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      gate_q     <= 1'b0;
      eng_rd_q   <= 1'b0;
      eng_addr_q <= '0;
      eng_data_q <= 8'h00;
    end else if (pop) begin
      gate_q     <= 1'b1;
      eng_rd_q   <= 1'b0;
      eng_addr_q <= fa_q[rp_q];
      eng_data_q <= fd_q[rp_q];
    end else if (load_rd) begin
      gate_q     <= 1'b1;
      eng_rd_q   <= 1'b1;
      eng_addr_q <= req_addr_q;
    end else if (done) begin
      gate_q <= 1'b0;
    end
  end

  assign bus_Pamux.address    = gate_q ? (BASE_ADDR | 22'(eng_addr_q)) : 'z;
  assign bus_Pamux.write      = gate_q ? ((state_q == E_STROBE) && !eng_rd_q) : 1'bz;
  assign bus_Pamux.read       = gate_q ? ((state_q == E_STROBE) && eng_rd_q) : 1'bz;
  assign bus_Pamux.write_data = gate_q ? eng_data_q : 'z;

  assign o_MEM_DATA8  = (i_EN && i_MEM_RD8) ? rdata_q : 'z;
  assign o_MEM_BUSY   = busy_q;
  assign o_WBUF_LEVEL = count_q;
  assign o_IDLE       = (state_q == E_IDLE) && fifo_empty && !rd_pend_q;

endmodule

// File: tb/tb_ram_window_unit.sv
// tb/tb_ram_window_unit.sv - scoreboard bench for ram_window_unit
module tb_ram_window_unit;
  localparam logic [21:0] BASE = 22'h00C000;

  typedef struct packed {
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  data;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [13:0] addr = '0;
  logic [7:0]  wdata = '0;
  wire  [7:0]  rdata_o;
  logic        busy_o, idle_o;
  logic [2:0]  level_o;
  logic        hold_busy = 1'b0;
  logic [7:0]  rd_word = 8'h00;
  logic [7:0]  mem [16384];

  bus_exp_t   exp_q[$];
  logic [7:0] rd_q[$];
  bus_exp_t   mon_e;
  logic [7:0] mon_d;
  logic       strobe_prev = 1'b0, busy_prev = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  bit saw;
  int n, cnt;

  pamux_if bus();
  assign bus.busy      = hold_busy;
  assign bus.read_data = rd_word;

  ram_window_unit #(.ADDR_W(14), .BASE_ADDR(BASE), .WBUF_DEPTH(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_EN(en),
    .i_MEM_ADDR(addr), .i_MEM_WR8(wr), .i_MEM_RD8(rd), .i_MEM_DATA8(wdata),
    .o_MEM_DATA8(rdata_o), .o_MEM_BUSY(busy_o), .o_WBUF_LEVEL(level_o), .o_IDLE(idle_o),
    .bus_Pamux(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: bus strobes against expected bus ops, read completions against expected data
  always @(negedge clk) begin
    if (rst) begin
      strobe_prev = 1'b0;
      busy_prev   = 1'b0;
    end else begin
      if (bus.write || bus.read) begin
        chk("strobe_one_cycle", 32'(strobe_prev), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bus_op: got addr %0h wr %0b expected none", bus.address, bus.write);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_kind", 32'(bus.write), 32'(mon_e.wr));
          chk("bus_addr", 32'(bus.address), 32'(mon_e.addr));
          if (mon_e.wr) chk("bus_wdata", 32'(bus.write_data), 32'(mon_e.data));
        end
        if (bus.write) mem[bus.address[13:0]] = bus.write_data;
        else           rd_word = mem[bus.address[13:0]];
      end
      strobe_prev = bus.write || bus.read;
      if (busy_prev && !busy_o && en && rd) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_read_done: got %0h expected none", rdata_o);
        end else begin
          mon_d = rd_q.pop_front();
          chk("read_data", 32'(rdata_o), 32'(mon_d));
        end
      end
      busy_prev = busy_o;
    end
  end

  task automatic cpu_write(input logic [13:0] a, input logic [7:0] d, input bit via_bus, output bit saw_busy);
    int guard;
    if (via_bus) exp_q.push_back('{1'b1, BASE | {8'b0, a}, d});
    en = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
    saw_busy = 1'b0;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
      if (busy_o) saw_busy = 1'b1;
    end while (busy_o && guard < 200);
    if (guard >= 200) chk("write_timeout", 32'(busy_o), 32'd0);
    en = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_read(output int busy_n);
    int guard;
    busy_n = 0;
    guard  = 0;
    do begin
      @(posedge clk); #1;
      guard++;
      if (busy_o) busy_n++;
    end while (busy_o && guard < 200);
    if (guard >= 200) chk("read_timeout", 32'(busy_o), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input logic [13:0] a, input logic [7:0] exp_d, input bit via_bus, output int busy_n);
    if (via_bus) exp_q.push_back('{1'b0, BASE | {8'b0, a}, 8'h00});
    rd_q.push_back(exp_d);
    en = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    wait_read(busy_n);
    en = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (!idle_o && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(name, 32'(idle_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_idle", 32'(idle_o), 32'd1);
    chk("reset_level", 32'(level_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single posted write: 5A to 0123 -> bus 0C123, no CPU stall
    cpu_write(14'h0123, 8'h5A, 1'b1, saw);
    chk("t1_no_busy", 32'(saw), 32'd0);
    wait_idle("t1_idle");

    // Engine held in a transaction, four writes fill the FIFO, the fifth stalls
    hold_busy = 1'b1;
    cpu_write(14'h0100, 8'hA0, 1'b1, saw);
    for (int i = 1; i <= 4; i++) cpu_write(14'h0100 + 14'(i), 8'hA0 + 8'(i), 1'b1, saw);
    chk("t2_level_full", 32'(level_o), 32'd4);
    fork
      cpu_write(14'h0105, 8'hA5, 1'b1, saw);
      begin
        repeat (10) @(posedge clk);
        #1 hold_busy = 1'b0;
      end
    join
    chk("t2_fifth_busy", 32'(saw), 32'd1);
    chk("t2_level_after", 32'(level_o), 32'd4);
    wait_idle("t2_idle");

    // Read-after-write ordering
    cpu_write(14'h0010, 8'h77, 1'b1, saw);
    cpu_read(14'h0010, 8'h77, 1'b1, n);
    chk("t3_read_busy", 32'(n > 0), 32'd1);
    wait_idle("t3_idle");

    // Reset while in E_WAIT_DONE with two entries queued
    hold_busy = 1'b1;
    cpu_write(14'h0030, 8'h31, 1'b1, saw);
    cpu_write(14'h0031, 8'h32, 1'b0, saw);
    cpu_write(14'h0032, 8'h33, 1'b0, saw);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_level_before", 32'(level_o), 32'd2);
    rst = 1'b1;
    hold_busy = 1'b0;
    @(posedge clk); #1;
    chk("t4_busy", 32'(busy_o), 32'd0);
    chk("t4_idle", 32'(idle_o), 32'd1);
    chk("t4_level", 32'(level_o), 32'd0);
    rst = 1'b0;
    en = 1'b1; rd = 1'b1; addr = 14'h0030;
    #1;
    chk("t4_rdata_reset", 32'(rdata_o), 32'h0CC);
    en = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    cpu_read(14'h0030, 8'h31, 1'b1, n);

    // i_EN held across two read requests: only the first is accepted
    exp_q.push_back('{1'b0, BASE | 22'h000010, 8'h00});
    rd_q.push_back(8'h77);
    en = 1'b1; rd = 1'b1; addr = 14'h0010;
    wait_read(n);
    chk("t5_first_busy", 32'(n > 0), 32'd1);
    rd = 1'b0;
    @(posedge clk); #1;
    rd = 1'b1; addr = 14'h0040;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy_o) cnt++;
    end
    chk("t5_no_second_accept", 32'(cnt), 32'd0);
    en = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    cpu_read(14'h0040, 8'hE5, 1'b1, n);
    chk("t5_reaccept_busy", 32'(n > 0), 32'd1);
    wait_idle("t5_idle");

`ifdef RAMWIN_RDCACHE_EN
    // Read cache: second read of 0200 hits, write-through updates it
    cpu_read(14'h0200, 8'hA5, 1'b1, n);
    cpu_read(14'h0200, 8'hA5, 1'b0, n);
    chk("c_hit_busy_one", 32'(n), 32'd1);
    cpu_write(14'h0200, 8'h11, 1'b1, saw);
    wait_idle("c_write_idle");
    cpu_read(14'h0200, 8'h11, 1'b0, n);
    chk("c_hit_after_write", 32'(n), 32'd1);
`endif

    wait_idle("final_idle");
    repeat (4) @(posedge clk);
    #1;
    chk("bus_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("read_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
